// File: rtl/pipe_stage_skid.sv
// Inter-stage pipeline register with valid/ready handshake, a one-entry
// skid buffer, synchronous flush with bubble insertion and a bubble counter.
//
// Ports:
//   clk, clrn            clock (rising edge), async active-low reset
//   flush                kill every held entry, refuse input this cycle
//   cnt_clr              clear bubble_cnt (wins over increment)
//   in_valid/in_ready    upstream handshake
//   in_ctrl, in_data     upstream control / data bundles
//   out_valid/out_ready  downstream handshake
//   out_ctrl, out_data   head entry (out_ctrl forced 0 while invalid)
//   bubble_cnt           saturating count of out_ready & !out_valid cycles

module pipe_stage_skid #(
    parameter int DATA_W = 128,
    parameter int CTRL_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              clrn,
    input  logic              flush,
    input  logic              cnt_clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  bubble_cnt
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_FULL  = 2'd1,
        S_SKID  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t state;
    state_t state_nxt;

    logic              skid_valid;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;

    logic accept;
    logic emit;
    logic ld_in;
    logic ld_skid;
    logic st_skid;

    // skid_valid is a flop, so in_ready only sees flush combinationally.
    assign in_ready = !skid_valid && !flush;
    assign accept   = in_valid && in_ready;
    assign emit     = out_valid && out_ready;

    always_comb begin
        state_nxt = state;
        ld_in     = 1'b0;
        ld_skid   = 1'b0;
        st_skid   = 1'b0;
        if (flush) begin
            state_nxt = S_EMPTY;
        end else begin
            unique case (state)
                S_EMPTY: begin
                    if (accept) begin
                        state_nxt = S_FULL;
                        ld_in     = 1'b1;
                    end
                end
                S_FULL: begin
                    if (accept && emit) begin
                        ld_in = 1'b1;
                    end else if (emit) begin
                        state_nxt = S_EMPTY;
                    end else if (accept) begin
                        state_nxt = S_SKID;
                        st_skid   = 1'b1;
                    end
                end
                S_SKID: begin
                    if (emit) begin
                        state_nxt = S_FULL;
                        ld_skid   = 1'b1;
                    end
                end
                default: begin
                    state_nxt = S_EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state      <= S_EMPTY;
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
        end else begin
            state      <= state_nxt;
            out_valid  <= (state_nxt != S_EMPTY);
            skid_valid <= (state_nxt == S_SKID);
        end
    end

    // Main register. Any move to EMPTY zeroes ctrl so a bubble can never
    // trigger register or memory writes downstream; data is left stale.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            out_ctrl <= '0;
            out_data <= '0;
        end else if (state_nxt == S_EMPTY) begin
            out_ctrl <= '0;
        end else if (ld_in) begin
            out_ctrl <= in_ctrl;
            out_data <= in_data;
        end else if (ld_skid) begin
            out_ctrl <= skid_ctrl;
            out_data <= skid_data;
        end
    end

    // Skid entry. Ctrl is cleared once the entry leaves or is flushed.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            skid_ctrl <= '0;
            skid_data <= '0;
        end else if (flush) begin
            skid_ctrl <= '0;
        end else if (st_skid) begin
            skid_ctrl <= in_ctrl;
            skid_data <= in_data;
        end else if (ld_skid) begin
            skid_ctrl <= '0;
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            bubble_cnt <= '0;
        end else if (cnt_clr) begin
            bubble_cnt <= '0;
        end else if (out_ready && !out_valid && bubble_cnt != CNT_MAX) begin
            bubble_cnt <= bubble_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: directed scenarios then random traffic,
// checked against a queue-based model of the stage.

module tb_pipe_stage_skid;

    typedef struct {
        logic [15:0]  ctrl;
        logic [127:0] data;
    } ent_t;

    logic         clk = 1'b0;
    logic         clrn;
    logic         flush;
    logic         cnt_clr;
    logic         in_valid;
    logic         in_ready;
    logic         in_ready3;
    logic [15:0]  in_ctrl;
    logic [127:0] in_data;
    logic         out_valid;
    logic         out_valid3;
    logic         out_ready;
    logic [15:0]  out_ctrl;
    logic [15:0]  out_ctrl3;
    logic [127:0] out_data;
    logic [127:0] out_data3;
    logic [15:0]  bubble_cnt;
    logic [2:0]   bubble_cnt3;

    int total = 0;
    int bad   = 0;

    ent_t q[$];
    int   cnt  = 0;
    int   cnt3 = 0;

    always #5 clk = ~clk;

    pipe_stage_skid #(.DATA_W(128), .CTRL_W(16), .CNT_W(16)) dut (
        .clk(clk), .clrn(clrn), .flush(flush), .cnt_clr(cnt_clr),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_ctrl(out_ctrl), .out_data(out_data),
        .bubble_cnt(bubble_cnt)
    );

    pipe_stage_skid #(.DATA_W(128), .CTRL_W(16), .CNT_W(3)) dut3 (
        .clk(clk), .clrn(clrn), .flush(flush), .cnt_clr(cnt_clr),
        .in_valid(in_valid), .in_ready(in_ready3),
        .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(out_valid3), .out_ready(out_ready),
        .out_ctrl(out_ctrl3), .out_data(out_data3),
        .bubble_cnt(bubble_cnt3)
    );

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag);
        chk({tag, ".out_valid"}, 128'(out_valid), 128'(q.size() > 0));
        chk({tag, ".out_ctrl"}, 128'(out_ctrl),
            q.size() > 0 ? 128'(q[0].ctrl) : 128'(0));
        if (q.size() > 0)
            chk({tag, ".out_data"}, out_data, q[0].data);
        chk({tag, ".bubble_cnt"}, 128'(bubble_cnt), 128'(cnt));
        chk({tag, ".bubble_cnt3"}, 128'(bubble_cnt3), 128'(cnt3));
    endtask

    // One clock: drive, check in_ready, advance model at the edge, check.
    task automatic cyc(input string tag, input logic v, input logic r,
                       input logic f, input logic c);
        ent_t e;
        int   sz;
        bit   acc;
        bit   em;
        in_valid  = v;
        out_ready = r;
        flush     = f;
        cnt_clr   = c;
        in_ctrl   = 16'($urandom);
        in_data   = {$urandom, $urandom, $urandom, $urandom};
        e.ctrl    = in_ctrl;
        e.data    = in_data;
        #1;
        sz = q.size();
        chk({tag, ".in_ready"}, 128'(in_ready), 128'(!f && sz < 2));
        @(posedge clk);
        acc = v && !f && sz < 2;
        em  = r && sz > 0;
        if (c) begin
            cnt  = 0;
            cnt3 = 0;
        end else if (r && sz == 0) begin
            if (cnt < 65535) cnt++;
            if (cnt3 < 7) cnt3++;
        end
        if (f) begin
            q.delete();
        end else begin
            if (em) void'(q.pop_front());
            if (acc) q.push_back(e);
        end
        #1;
        chk_out(tag);
    endtask

    initial begin
        clrn      = 1'b0;
        flush     = 1'b0;
        cnt_clr   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_ctrl   = '0;
        in_data   = '0;
        #3;
        chk("rst.in_ready", 128'(in_ready), 128'(1));
        chk_out("rst");
        chk("rst.out_data", out_data, 128'(0));
        #9;
        clrn = 1'b1;

        // Stream of four with downstream always ready.
        for (int i = 0; i < 4; i++) cyc("stream", 1, 1, 0, 0);
        chk("stream.tail_valid", 128'(out_valid), 128'(1));
        cyc("stream", 0, 1, 0, 0);
        cyc("stream", 0, 1, 0, 0);

        // Backpressure: A in main, B in skid, C held upstream.
        for (int i = 0; i < 4; i++) cyc("bp", 1, 0, 0, 0);
        chk("bp.in_ready_low", 128'(in_ready), 128'(0));
        for (int i = 0; i < 4; i++) cyc("bp_drain", 1, 1, 0, 0);
        for (int i = 0; i < 4; i++) cyc("bp_drain", 0, 1, 0, 0);

        // Flush in SKID state.
        cyc("fl_fill", 1, 0, 0, 0);
        cyc("fl_fill", 1, 0, 0, 0);
        cyc("fl_skid", 1, 0, 1, 0);
        chk("fl.out_valid0", 128'(out_valid), 128'(0));
        chk("fl.out_ctrl0", 128'(out_ctrl), 128'(0));
        cyc("fl_after", 0, 1, 0, 0);

        // Flush with input offered while EMPTY.
        cyc("fl_empty", 1, 1, 1, 0);
        cyc("fl_empty2", 0, 0, 0, 0);

        // Async reset while FULL.
        cyc("ar_fill", 1, 0, 0, 0);
        cyc("ar_fill", 0, 1, 0, 0);
        cyc("ar_fill", 1, 0, 0, 0);
        clrn = 1'b0;
        #2;
        q.delete();
        cnt  = 0;
        cnt3 = 0;
        chk_out("ar_mid");
        chk("ar_mid.out_data", out_data, 128'(0));
        clrn = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) cyc("ar_resume", 1, 1, 0, 0);
        cyc("ar_resume", 0, 1, 0, 0);

        // Bubble counter count, saturation and clear.
        cyc("bc_clr", 0, 1, 0, 1);
        for (int i = 0; i < 5; i++) cyc("bc_run", 0, 1, 0, 0);
        chk("bc.five", 128'(bubble_cnt), 128'(5));
        for (int i = 0; i < 5; i++) cyc("bc_sat", 0, 1, 0, 0);
        chk("bc.sat3", 128'(bubble_cnt3), 128'(7));
        chk("bc.ten", 128'(bubble_cnt), 128'(10));
        cyc("bc_clr2", 0, 1, 0, 1);
        chk("bc.cleared", 128'(bubble_cnt), 128'(0));

        // Random traffic.
        for (int i = 0; i < 400; i++)
            cyc("rand", 1'($urandom_range(0, 99) < 65),
                1'($urandom_range(0, 99) < 55),
                1'($urandom_range(0, 99) < 4),
                1'($urandom_range(0, 99) < 2));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
